// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one W x W multiplier between two requesters.
// Optional macro MUL_ARB_BYPASS_EN returns trivial products (operand 0 or 1) without the multiplier.
module mul_arbiter #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  output logic           rsp0_valid,
  output logic [2*W-1:0] rsp0_result,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp1_valid,
  output logic [2*W-1:0] rsp1_result,
  output logic [W-1:0]   m_multiplicand,
  output logic [W-1:0]   m_multiplier,
  output logic           m_opstart,
  output logic           m_opclear,
  input  logic           m_opdone,
  input  logic [2*W-1:0] m_result,
  output logic           busy,
  output logic           owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sel_a, sel_b;
  logic [2*W-1:0] r0_q, r0_d, r1_q, r1_d, res_in;
  logic idle, acc, byp, take, dst;
  assign idle = state_q == IDLE;
  assign req0_ready = idle && req0_valid && (!req1_valid || last_q);
  assign req1_ready = idle && req1_valid && (!req0_valid || !last_q);
  assign acc = req0_ready || req1_ready;
  assign sel_a = req1_ready ? req1_a : req0_a;
  assign sel_b = req1_ready ? req1_b : req0_b;
`ifdef MUL_ARB_BYPASS_EN
  assign byp = acc && (sel_a == '0 || sel_b == '0 || sel_a == W'(1) || sel_b == W'(1));
  assign res_in = !idle ? m_result :
                  (sel_a == '0 || sel_b == '0) ? '0 :
                  sel_a == W'(1) ? {{W{1'b0}}, sel_b} : {{W{1'b0}}, sel_a};
`else
  assign byp = 1'b0;
  assign res_in = m_result;
`endif
  // done is only honoured in WAIT; a level left over from the previous op is ignored in ISSUE
  assign take = byp || (state_q == WAIT && m_opdone);
  assign dst = idle ? req1_ready : owner_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    a_d = a_q;
    b_d = b_q;
    r0_d = r0_q;
    r1_d = r1_q;
    state_d = idle ? (byp ? RESP : acc ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT ? (m_opdone ? RESP : WAIT) : IDLE;
    owner_d = acc ? req1_ready : owner_q;
    last_d = acc ? req1_ready : last_q;
    a_d = acc ? sel_a : a_q;
    b_d = acc ? sel_b : b_q;
    r0_d = (take && !dst) ? res_in : r0_q;
    r1_d = (take && dst) ? res_in : r1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      a_q <= '0;
      b_q <= '0;
      r0_q <= '0;
      r1_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      a_q <= a_d;
      b_q <= b_d;
      r0_q <= r0_d;
      r1_q <= r1_d;
    end
  end
  assign m_multiplicand = a_q;
  assign m_multiplier = b_q;
  assign m_opstart = state_q == ISSUE || state_q == WAIT;
  assign m_opclear = idle || state_q == RESP;
  assign busy = !idle;
  assign owner = owner_q;
  assign rsp0_valid = state_q == RESP && !owner_q;
  assign rsp1_valid = state_q == RESP && owner_q;
  assign rsp0_result = r0_q;
  assign rsp1_result = r1_q;
endmodule
